tb_bank_loader: RTL and testbench
=================================

# tb_bank_loader

Parametrised, back-pressured loader that streams a serial word image from the verification environment into the DPU's banked data memories, one word per cycle. It replaces the single-bank, fixed-width preload with configurable word width, bank count, bank depth and two fill modes, and adds completion, overflow and checksum reporting. It sits between the bench's stimulus source and the DUT's memory write ports; it is compiled only when `VERIFICATION` is defined.

## Interface
- `WORD_L`, 32: data word width in bits.
- `NUM_BANKS`, 16: number of target memory banks (≥2).
- `BANK_DEPTH`, 512: words per bank (power of two).
- `ADDR_L`, $clog2(BANK_DEPTH): bank address width (derived).
- `CNT_L`, $clog2(NUM_BANKS*BANK_DEPTH+1): word count width (derived).

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode`  in  1  0 = ROUND_ROBIN, 1 = SEQUENTIAL; sampled with `start`.
- `base_addr`  in  ADDR_L  first address in each bank; sampled with `start`.
- `num_words`  in  CNT_L  words to load; sampled with `start`.
- `in_vld`  in  1  stream word valid.
- `in_data`  in  WORD_L  stream word.
- `in_rdy`  out  1  loader accepts a word.
- `wr_en`  out  NUM_BANKS  one-hot bank write enable.
- `wr_addr`  out  ADDR_L  shared write address.
- `wr_data`  out  WORD_L  shared write data.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  capacity overflow; sticky until next accepted `start`.
- `word_cnt`  out  CNT_L  words accepted in current/last transfer.
- `checksum`  out  WORD_L  XOR of all accepted words.

## Operation
- States: IDLE, LOAD, FINISH. Reset enters IDLE; every output resets to 0.
- IDLE + `start`: latch `mode`, `base_addr`, `num_words`; clear `err`, `word_cnt`, `checksum`; cursor = bank 0, addr `base_addr`. `num_words`==0 -> FINISH, else LOAD.
- LOAD: `in_rdy`=1. Handshake = `in_vld && in_rdy`. Each handshake writes the cursor location, XORs into `checksum`, increments `word_cnt`, advances cursor.
- ROUND_ROBIN advance: bank+1; after bank NUM_BANKS-1, bank wraps to 0 and addr+1.
- SEQUENTIAL advance: addr+1; after addr BANK_DEPTH-1, bank+1 and addr returns to `base_addr`.
- Overflow: words remain but cursor is at the last location (bank NUM_BANKS-1, addr BANK_DEPTH-1 in either mode) after a write -> `err`=1, go to FINISH; no further words accepted.
- Last word accepted (`word_cnt` reaches `num_words`) -> FINISH.
- FINISH: `done`=1 for one cycle, then IDLE. `word_cnt`, `checksum`, `err` hold until the next `start`.
- `start` outside IDLE is ignored. Changes to `mode`/`base_addr`/`num_words` during LOAD have no effect.

## Timing
- `busy`=1 from the cycle after `start` until (excluding) the cycle after `done`.
- Write latency 1: handshake at cycle t -> `wr_en`/`wr_addr`/`wr_data` registered at t+1, valid one cycle.
- Throughput one word per cycle with `in_vld` held high; `in_vld` gaps insert bubbles, no words lost.
- Last handshake at t -> last write and `done` at t+1. `num_words`==0: `start` at t -> `done` at t+1, no `wr_en`.
- `in_rdy` drops combinationally in the cycle LOAD exits (it is a decode of the registered state).
- `rst_n` low mid-transfer: immediate clear of all state and outputs, no `done`; partial bank contents are not tracked.

## Structure
- Shared package `common_types_params`: `load_mode_t` enum (ROUND_ROBIN, SEQUENTIAL) and `loader_state_t` enum (IDLE, LOAD, FINISH).
- Sub-module `tb_bank_cursor`: bank/address counter with mode-dependent advance, base reload and last-location flag.

## Test plan
- NUM_BANKS=4, BANK_DEPTH=8, ROUND_ROBIN, base 0, 6 words 0x1..0x6, `in_vld` constant -> writes (b0,a0)=1,(b1,a0)=2,(b2,a0)=3,(b3,a0)=4,(b0,a1)=5,(b1,a1)=6; `done` with last write; checksum 0x7.
- SEQUENTIAL, base 6, 4 words -> (b0,a6),(b0,a7),(b1,a6),(b1,a7); `word_cnt`=4, `err`=0.
- ROUND_ROBIN, base 7, 10 words -> 4 writes at addr 7, then `err`=1, `done`, `word_cnt`=4, `in_rdy` low afterwards.
- `num_words`=0 -> `done` one cycle after `start`, no `wr_en`, `busy` one cycle.
- Random `in_vld` gaps over 32 words plus a second `start` during LOAD -> all 32 written in order, second `start` ignored; `rst_n` pulse mid-transfer -> all outputs 0, no `done`.

Source files
------------

// File: rtl/tb_bank_loader_pkg.sv
// Shared types for the bank loader: fill mode and controller state encodings.
package common_types_params;

    typedef enum logic {
        ROUND_ROBIN = 1'b0,
        SEQUENTIAL  = 1'b1
    } load_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } loader_state_t;

endpackage : common_types_params

// File: rtl/tb_bank_cursor.sv
// Bank/address cursor for the bank loader: reloads on a new transfer,
// advances one location per accepted word and flags the last location.
module tb_bank_cursor
    import common_types_params::*;
#(
    parameter int unsigned NUM_BANKS  = 16,
    parameter int unsigned BANK_DEPTH = 512,
    parameter int unsigned ADDR_L     = $clog2(BANK_DEPTH),
    parameter int unsigned BANK_L     = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_L-1:0] base_i,
    input  load_mode_t        mode_i,
    input  logic              adv_i,
    output logic [BANK_L-1:0] bank_o,
    output logic [ADDR_L-1:0] addr_o,
    output logic              last_c
);

    logic [BANK_L-1:0] bank_q, bank_d;
    logic [ADDR_L-1:0] addr_q, addr_d;
    logic [ADDR_L-1:0] base_q, base_d;
    load_mode_t        mode_q, mode_d;
    logic              bank_end;
    logic              addr_end;

    assign bank_end = (bank_q == BANK_L'(NUM_BANKS - 1));
    assign addr_end = (addr_q == ADDR_L'(BANK_DEPTH - 1));

    // Next cursor position: reload on a new transfer, otherwise mode-dependent step
    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        base_d = base_q;
        mode_d = mode_q;
        if (load_i) begin
            bank_d = '0;
            addr_d = base_i;
            base_d = base_i;
            mode_d = mode_i;
        end else if (adv_i) begin
            if (mode_q == ROUND_ROBIN) begin
                if (bank_end) begin
                    bank_d = '0;
                    addr_d = addr_q + ADDR_L'(1);
                end else begin
                    bank_d = bank_q + BANK_L'(1);
                end
            end else begin
                if (addr_end) begin
                    bank_d = bank_q + BANK_L'(1);
                    addr_d = base_q;
                end else begin
                    addr_d = addr_q + ADDR_L'(1);
                end
            end
        end
    end

    // Cursor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
            addr_q <= '0;
            base_q <= '0;
            mode_q <= ROUND_ROBIN;
        end else begin
            bank_q <= bank_d;
            addr_q <= addr_d;
            base_q <= base_d;
            mode_q <= mode_d;
        end
    end

    assign bank_o = bank_q;
    assign addr_o = addr_q;
    assign last_c = bank_end && addr_end;

endmodule : tb_bank_cursor

// File: rtl/tb_bank_loader.sv
// Back-pressured loader streaming a word image into banked memories with
// completion, overflow and checksum reporting.
module tb_bank_loader
    import common_types_params::*;
#(
    parameter int unsigned WORD_L     = 32,
    parameter int unsigned NUM_BANKS  = 16,
    parameter int unsigned BANK_DEPTH = 512,
    parameter int unsigned ADDR_L     = $clog2(BANK_DEPTH),
    parameter int unsigned CNT_L      = $clog2(NUM_BANKS * BANK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_L-1:0]    base_addr,
    input  logic [CNT_L-1:0]     num_words,
    input  logic                 in_vld,
    input  logic [WORD_L-1:0]    in_data,
    output logic                 in_rdy,
    output logic [NUM_BANKS-1:0] wr_en,
    output logic [ADDR_L-1:0]    wr_addr,
    output logic [WORD_L-1:0]    wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_L-1:0]     word_cnt,
    output logic [WORD_L-1:0]    checksum
);

    localparam int unsigned BANK_L = $clog2(NUM_BANKS);

    loader_state_t        state_q, state_d;
    logic [CNT_L-1:0]     num_q, num_d;
    logic [CNT_L-1:0]     cnt_q, cnt_d;
    logic [WORD_L-1:0]    csum_q, csum_d;
    logic                 err_q, err_d;
    logic [NUM_BANKS-1:0] wr_en_q, wr_en_d;
    logic [ADDR_L-1:0]    wr_addr_q, wr_addr_d;
    logic [WORD_L-1:0]    wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 cur_load;
    logic                 cur_adv;
    logic [BANK_L-1:0]    cur_bank;
    logic [ADDR_L-1:0]    cur_addr;
    logic                 cur_last;

    tb_bank_cursor #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_DEPTH (BANK_DEPTH),
        .ADDR_L     (ADDR_L),
        .BANK_L     (BANK_L)
    ) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cur_load),
        .base_i (base_addr),
        .mode_i (load_mode_t'(mode)),
        .adv_i  (cur_adv),
        .bank_o (cur_bank),
        .addr_o (cur_addr),
        .last_c (cur_last)
    );

    // Ready is a pure decode of the registered state
    assign in_rdy = (state_q == LOAD);

    // Next-state, transfer bookkeeping and write-port staging
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        err_d     = err_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cur_load  = 1'b0;
        cur_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d    = num_words;
                    cnt_d    = '0;
                    csum_d   = '0;
                    err_d    = 1'b0;
                    cur_load = 1'b1;
                    state_d  = (num_words == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (in_vld) begin
                    wr_en_d   = NUM_BANKS'(1) << cur_bank;
                    wr_addr_d = cur_addr;
                    wr_data_d = in_data;
                    csum_d    = csum_q ^ in_data;
                    cnt_d     = cnt_q + CNT_L'(1);
                    cur_adv   = 1'b1;
                    if ((cnt_q + CNT_L'(1)) == num_q) begin
                        state_d = FINISH;
                    end else if (cur_last) begin
                        // Words remain but the memory is full
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = cnt_q;
    assign checksum = csum_q;

endmodule : tb_bank_loader

// File: tb/tb_tb_bank_loader.sv
// Randomized self-checking bench for tb_bank_loader (4 banks x 8 words).
module tb_tb_bank_loader;

    localparam int unsigned WORD_L = 32;
    localparam int unsigned NB     = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_L = $clog2(DEPTH);
    localparam int unsigned CNT_L  = $clog2(NB * DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [ADDR_L-1:0] base_addr;
    logic [CNT_L-1:0]  num_words;
    logic              in_vld;
    logic [WORD_L-1:0] in_data;
    logic              in_rdy;
    logic [NB-1:0]     wr_en;
    logic [ADDR_L-1:0] wr_addr;
    logic [WORD_L-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_L-1:0]  word_cnt;
    logic [WORD_L-1:0] checksum;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt;
    int busy_cnt;
    int done_cyc;
    int last_wr_cyc;
    logic [47:0] obs[$];

    tb_bank_loader #(
        .WORD_L     (WORD_L),
        .NUM_BANKS  (NB),
        .BANK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .num_words (num_words),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Where the k-th word of a transfer must land, from the fill-mode rules
    function automatic logic [47:0] exp_loc(input bit m, input int base, input int k,
                                            input logic [WORD_L-1:0] d);
        int b, a, span;
        if (!m) begin
            b = k % NB;
            a = base + k / NB;
        end else begin
            span = DEPTH - base;
            b = k / span;
            a = base + k % span;
        end
        return {8'(b), 8'(a), d};
    endfunction

    // Write-port and status monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en != '0) begin
                check("onehot", 64'($countones(wr_en)), 64'd1);
                last_wr_cyc = cyc;
                for (int b = 0; b < NB; b++)
                    if (wr_en[b]) obs.push_back({8'(b), 8'(wr_addr), wr_data});
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic run_xfer(input bit m, input int base, input int n, input int pct,
                            input bit fixed_data, input bit restart);
        logic [WORD_L-1:0] words[$];
        logic [WORD_L-1:0] xs;
        int idx, t, acc, cap, st_cyc;
        bit exp_err;
        for (int k = 0; k < n; k++)
            words.push_back(fixed_data ? WORD_L'(k + 1) : WORD_L'($urandom));
        obs.delete();
        done_cnt = 0; busy_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
        @(negedge clk); #1;
        start = 1'b1; mode = m; base_addr = ADDR_L'(base); num_words = CNT_L'(n);
        @(negedge clk); #1;
        start = 1'b0; mode = 1'($urandom); base_addr = ADDR_L'($urandom);
        num_words = CNT_L'($urandom);
        st_cyc = cyc;
        check("busy_go", busy, 1);
        idx = 0; t = 0;
        while (done_cnt == 0 && t < 400) begin
            in_vld  = (idx < n) && (int'($urandom_range(99)) < pct);
            in_data = (idx < n) ? words[idx] : '0;
            if (restart && t == 3) begin
                start = 1'b1; mode = ~m; base_addr = ADDR_L'(3); num_words = CNT_L'(1);
            end
            if (in_vld && in_rdy) idx++;
            @(negedge clk); #1;
            start = 1'b0; t++;
        end
        in_vld = 1'b0;
        if (done_cnt == 0) check("timeout", 0, 1);
        repeat (2) begin @(negedge clk); #1; end
        cap = NB * (DEPTH - base);
        acc = (n < cap) ? n : cap;
        exp_err = (n > cap);
        xs = '0;
        check("nwrites", obs.size(), acc);
        for (int k = 0; k < acc; k++) begin
            xs ^= words[k];
            if (k < obs.size()) check("wr_loc", obs[k], exp_loc(m, base, k, words[k]));
        end
        check("word_cnt", word_cnt, acc);
        check("err", err, exp_err);
        check("checksum", checksum, xs);
        check("done_cnt", done_cnt, 1);
        if (acc > 0) check("done_last", done_cyc, last_wr_cyc);
        else         check("done_lat", done_cyc, st_cyc);
        if (n == 0)  check("busy_cnt", busy_cnt, 1);
        else         check("busy_cnt", busy_cnt, done_cyc - st_cyc + 1);
        check("in_rdy_idle", in_rdy, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; num_words = '0;
        in_vld = 1'b0; in_data = '0;
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_checksum", checksum, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        run_xfer(1'b0, 0, 6, 100, 1'b1, 1'b0);
        check("csum_1to6", checksum, 7);
        run_xfer(1'b1, 6, 4, 100, 1'b0, 1'b0);
        run_xfer(1'b0, 7, 10, 100, 1'b0, 1'b0);
        check("ovf_cnt", word_cnt, 4);
        run_xfer(1'b0, 3, 0, 100, 1'b0, 1'b0);
        run_xfer(1'b1, 0, 0, 100, 1'b0, 1'b0);

        // Gapped 32-word fill with an ignored second start
        run_xfer(1'b0, 0, 32, 60, 1'b0, 1'b1);
        run_xfer(1'b1, 0, 32, 50, 1'b0, 1'b1);

        // Random transfers, including overflow and empty cases
        for (int i = 0; i < 8; i++)
            run_xfer(1'($urandom), int'($urandom_range(7)), int'($urandom_range(40)),
                     int'($urandom_range(100, 30)), 1'b0, 1'b0);

        // Reset in the middle of a transfer
        obs.delete(); done_cnt = 0;
        @(negedge clk); #1;
        start = 1'b1; mode = 1'b0; base_addr = '0; num_words = CNT_L'(20);
        @(negedge clk); #1;
        start = 1'b0; in_vld = 1'b1; in_data = $urandom;
        repeat (5) begin @(negedge clk); #1; in_data = $urandom; end
        check("pre_rst_cnt", word_cnt, 5);
        rst_n = 1'b0;
        #1;
        check("mrst_wr_en", wr_en, 0);
        check("mrst_wr_addr", wr_addr, 0);
        check("mrst_wr_data", wr_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        check("mrst_word_cnt", word_cnt, 0);
        check("mrst_checksum", checksum, 0);
        check("mrst_in_rdy", in_rdy, 0);
        in_vld = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        check("mrst_no_done", done_cnt, 0);
        check("mrst_idle", busy, 0);

        // Recovery after reset
        run_xfer(1'b1, 2, 9, 80, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_tb_bank_loader
